// File: rtl/fu_mul_arbiter.sv
// Round-robin arbiter that shares one multi-cycle FU_mul between NUM_REQ requesters,
// holding each result with its tag until the CDB accepts it, with flush and timeout handling.
module fu_mul_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*32-1:0]    req_a,
    input  logic [NUM_REQ*32-1:0]    req_b,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     fu_en,
    output logic [31:0]              fu_a,
    output logic [31:0]              fu_b,
    input  logic [31:0]              fu_res,
    input  logic                     fu_finish,
    output logic                     res_valid,
    output logic [31:0]              res_data,
    output logic [TAG_W-1:0]         res_tag,
    input  logic                     res_ack,
    input  logic                     flush,
    output logic                     busy,
    output logic                     err
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE, S_DRAIN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  win;
    logic              found;
    int unsigned       idx;
    logic [CNT_W-1:0]  cnt;
    logic              take;
    logic              waiting;
    logic              tmo;
    logic [31:0]       a_arr   [NUM_REQ];
    logic [31:0]       b_arr   [NUM_REQ];
    logic [TAG_W-1:0]  tag_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign a_arr[g]   = req_a[g*32 +: 32];
        assign b_arr[g]   = req_b[g*32 +: 32];
        assign tag_arr[g] = req_tag[g*TAG_W +: TAG_W];
    end

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        win   = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[IDX_W'(idx)]) begin
                win   = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign take    = !rst && (state == S_IDLE) && !flush && (|req);
    assign gnt     = take ? (NUM_REQ'(1) << win) : '0;
    assign waiting = (state == S_BUSY) || (state == S_DRAIN);
    // cnt holds cycles elapsed since fu_en; err lands exactly TIMEOUT cycles after it.
    assign tmo     = waiting && !fu_finish && (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (take) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = flush ? S_DRAIN : S_BUSY;
            S_BUSY: begin
                if (fu_finish)  state_nxt = flush ? S_IDLE : S_DONE;
                else if (tmo)   state_nxt = S_IDLE;
                else if (flush) state_nxt = S_DRAIN;
            end
            S_DONE:  if (flush || res_ack) state_nxt = S_IDLE;
            S_DRAIN: if (fu_finish || tmo) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            fu_en     <= 1'b0;
            fu_a      <= '0;
            fu_b      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tag   <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            fu_en <= (state_nxt == S_ISSUE);
            busy  <= (state_nxt != S_IDLE);
            if (take) begin
                fu_a    <= a_arr[win];
                fu_b    <= b_arr[win];
                res_tag <= tag_arr[win];
                rr_ptr  <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end
            if ((state == S_ISSUE) || waiting) cnt <= cnt + 1'b1;
            else                               cnt <= '0;
            if ((state == S_BUSY) && (state_nxt == S_DONE)) begin
                res_valid <= 1'b1;
                res_data  <= fu_res;
            end else if ((state == S_DONE) && (state_nxt == S_IDLE)) begin
                res_valid <= 1'b0;
            end
            if (tmo) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fu_mul_arbiter.sv
// Self-checking bench for fu_mul_arbiter: FU_mul stub plus a transaction-level
// round-robin/product model, directed corner cases and randomized operations.
module tb_fu_mul_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned TW = 4;
    localparam int unsigned TO = 31;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N*TW-1:0] req_tag;
    logic [N-1:0]    gnt;
    logic            fu_en;
    logic [31:0]     fu_a;
    logic [31:0]     fu_b;
    logic [31:0]     fu_res;
    logic            fu_finish;
    logic            res_valid;
    logic [31:0]     res_data;
    logic [TW-1:0]   res_tag;
    logic            res_ack;
    logic            flush;
    logic            busy;
    logic            err;

    int          total = 0;
    int          bad   = 0;
    int          mptr  = 0;
    int          fu_cnt = 0;
    int          fu_lat = 7;
    logic [31:0] fu_prod;
    logic [31:0] ma [N];
    logic [31:0] mb [N];
    logic [TW-1:0] mt [N];

    fu_mul_arbiter #(.NUM_REQ(N), .TAG_W(TW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .gnt(gnt), .fu_en(fu_en), .fu_a(fu_a), .fu_b(fu_b), .fu_res(fu_res),
        .fu_finish(fu_finish), .res_valid(res_valid), .res_data(res_data),
        .res_tag(res_tag), .res_ack(res_ack), .flush(flush), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; FU_mul stub finishes fu_lat cycles after EN (fu_lat=0: never).
    task automatic tick();
        @(posedge clk);
        #1;
        fu_finish = 1'b0;
        if (fu_cnt > 0) begin
            fu_cnt--;
            if (fu_cnt == 0) begin
                fu_finish = 1'b1;
                fu_res    = fu_prod;
            end
        end
        if (fu_en === 1'b1 && fu_lat > 0) begin
            fu_cnt  = fu_lat;
            fu_prod = fu_a * fu_b;
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32]  = ma[i];
            req_b[i*32 +: 32]  = mb[i];
            req_tag[i*TW +: TW] = mt[i];
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            if (r[(mptr + i) % N]) return (mptr + i) % N;
        end
        return 0;
    endfunction

    task automatic check_zero(input string nm);
        chk({nm, " ctl"}, {gnt, fu_en, res_valid, busy, err, res_tag}, 64'd0);
        chk({nm, " fu_ab"}, {fu_a, fu_b}, 64'd0);
        chk({nm, " res_data"}, res_data, 64'd0);
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1; req = '0; flush = 1'b0; res_ack = 1'b0; fu_cnt = 0;
        tick();
        check_zero(nm);
        rst = 1'b0;
        mptr = 0;
    endtask

    // One full operation with the model-selected requester; caller sets req.
    task automatic do_op(input int ack_delay, input string nm);
        int w, k;
        logic viol;
        logic [31:0] ea, eb, ep, held;
        logic [TW-1:0] et;
        flush = 1'b0; res_ack = 1'b0;
        #1;
        w = pick(req);
        chk({nm, " gnt"}, gnt, 64'(1) << w);
        ea = ma[w]; eb = mb[w]; et = mt[w]; ep = ea * eb;
        mptr = (w + 1) % N;
        tick();
        chk({nm, " issue"}, {fu_en, busy, fu_a, fu_b}, {2'b11, ea, eb});
        k = 0; viol = 1'b0;
        while (res_valid !== 1'b1 && k < 40) begin
            tick();
            k++;
            if (gnt !== '0 || fu_en !== 1'b0) viol = 1'b1;
        end
        chk({nm, " latency"}, 64'(k), 64'(fu_lat + 1));
        chk({nm, " result"}, {res_tag, res_data}, {et, ep});
        held = res_data;
        for (int d = 0; d < ack_delay; d++) begin
            tick();
            if (res_valid !== 1'b1 || res_data !== held || res_tag !== et ||
                gnt !== '0 || fu_en !== 1'b0) viol = 1'b1;
        end
        chk({nm, " hold"}, 64'(viol), 64'd0);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        chk({nm, " consumed"}, {res_valid, busy}, 64'd0);
    endtask

    // Flush fc cycles after the grant; result must never surface.
    task automatic flush_op(input int fc, input string nm);
        int w, idle_k;
        logic viol, ok_valid;
        flush = 1'b0; res_ack = 1'b0;
        #1;
        w = pick(req);
        chk({nm, " gnt"}, gnt, 64'(1) << w);
        mptr = (w + 1) % N;
        idle_k = (fc <= fu_lat + 1) ? fu_lat + 2 : fc + 1;
        viol = 1'b0;
        for (int k = 1; k <= idle_k; k++) begin
            tick();
            flush = (k == fc);
            #1;
            if (k < idle_k) begin
                ok_valid = (fc > fu_lat + 1) && (k > fu_lat + 1);
                if (busy !== 1'b1 || gnt !== '0 || res_valid !== ok_valid) viol = 1'b1;
            end
        end
        chk({nm, " drain"}, 64'(viol), 64'd0);
        chk({nm, " idle"}, {busy, res_valid}, 64'd0);
        chk({nm, " regrant"}, gnt, 64'(1) << pick(req));
        req = '0;
        tick();
    endtask

    initial begin
        int k;
        rst = 1'b1; req = '0; req_a = '0; req_b = '0; req_tag = '0;
        fu_res = '0; fu_finish = 1'b0; res_ack = 1'b0; flush = 1'b0;
        for (int i = 0; i < N; i++) begin ma[i] = '0; mb[i] = '0; mt[i] = '0; end
        tick();
        do_reset("reset");

        // Single op: 6*7 tag 3 on requester 0
        ma[0] = 32'd6; mb[0] = 32'd7; mt[0] = 4'd3; drive_ops();
        req = 4'b0001;
        do_op(0, "single");
        req = '0;

        // Round-robin with all requests held
        do_reset("rr_reset");
        for (int i = 0; i < N; i++) begin
            ma[i] = $urandom(); mb[i] = $urandom(); mt[i] = TW'($urandom_range(0, 15));
        end
        drive_ops();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_order", gnt, 64'(1) << (i % N));
            do_op(i % 2, "rr");
        end
        req = '0;

        // CDB backpressure
        req = 4'b0010;
        do_op(20, "stall");
        req = '0;

        // Wrap product and max tag
        ma[2] = 32'hFFFF_FFFF; mb[2] = 32'd2; mt[2] = 4'd15; drive_ops();
        req = 4'b0100;
        do_op(1, "wrap");
        req = '0;
        tick();

        // Flush in ISSUE, BUSY, coincident with finish, and in DONE
        req = 4'b1011; flush_op(1, "flush_issue");
        req = 4'b1011; flush_op(4, "flush_busy");
        req = 4'b1011; flush_op(8, "flush_finish");
        req = 4'b1011; flush_op(9, "flush_done");

        // Randomized operations
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < N; i++) begin
                ma[i] = $urandom(); mb[i] = $urandom(); mt[i] = TW'($urandom_range(0, 15));
            end
            drive_ops();
            fu_lat = $urandom_range(1, 12);
            req = N'($urandom_range(1, 15));
            do_op($urandom_range(0, 3), "rand");
        end
        fu_lat = 7;
        req = '0;
        tick();

        // Reset in the middle of BUSY
        req = 4'b0001;
        #1;
        tick(); tick(); tick(); tick();
        do_reset("mid_busy_reset");
        tick(); tick(); tick(); tick(); tick();

        // FU never finishes: err exactly TO cycles after fu_en
        fu_lat = 0;
        req = 4'b0001;
        #1;
        chk("tmo gnt", gnt, 64'd1);
        mptr = 1;
        tick();
        chk("tmo fu_en", fu_en, 64'd1);
        req = '0;
        k = 0;
        while (err !== 1'b1 && k < 60) begin
            tick();
            k++;
            if (res_valid !== 1'b0) k = 100;
        end
        chk("tmo cycles", 64'(k), 64'(TO));
        chk("tmo idle", {busy, res_valid}, 64'd0);

        // err is sticky across a normal op, cleared by reset
        fu_lat = 7;
        req = 4'b0010;
        do_op(0, "after_tmo");
        req = '0;
        chk("err sticky", err, 64'd1);
        do_reset("final_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
